gpu_mem_cmd_arbiter: RTL

- Shares the single GPU memory command FIFO between up to NUM_REQ command sources: CPU→VRAM copy, VRAM→VRAM copy, VRAM→CPU copy/fill, and the rasterizer.
- Round-robin arbitration, with a lock so multi-beat sequences (stencil read-modify-write, L/M pixel pairs) reach the FIFO unbroken.
- Registered single-entry output stage with valid/ready toward the FIFO.
- A lock watchdog guarantees forward progress if a lock holder stalls.

---
 rtl/gpu_def.sv | 28 ++
 rtl/gpu_rr_picker.sv | 30 +++
 rtl/gpu_mem_cmd_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/gpu_def.sv
// Shared GPU definitions: memory command codes, arbiter state type and requester indices.
package gpu_def;

  localparam logic [2:0] MEM_CMD_NONE       = 3'd0;
  localparam logic [2:0] MEM_CMD_PIXEL2VRAM = 3'd1;
  localparam logic [2:0] MEM_CMD_VRAM2PIXEL = 3'd2;
  localparam logic [2:0] MEM_CMD_VRAM2VRAM  = 3'd3;
  localparam logic [2:0] MEM_CMD_FILLVRAM   = 3'd4;
  localparam logic [2:0] MEM_CMD_STENCIL_RD = 3'd5;
  localparam logic [2:0] MEM_CMD_STENCIL_WR = 3'd6;

  typedef enum logic [0:0] {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arbState_t;

  localparam int REQ_COPYCV = 0;
  localparam int REQ_COPYVV = 1;
  localparam int REQ_COPYVC = 2;
  localparam int REQ_RASTER = 3;

  // Round-robin successor of a requester index among n requesters.
  function automatic logic [2:0] rr_next(input logic [2:0] idx, input int n);
    if (int'(idx) + 1 >= n) return 3'd0;
    return idx + 3'd1;
  endfunction

endpackage

// File: rtl/gpu_rr_picker.sv
// Combinational rotating priority encoder: first set request at or above i_ptr, with wrap.
module gpu_rr_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_req,
  input  logic [2:0]   i_ptr,
  output logic [N-1:0] o_grant,
  output logic [2:0]   o_idx,
  output logic         o_any
);

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = int'(i_ptr) + k;
      if (j >= N) j = j - N;
      for (int n = 0; n < N; n++) begin
        if (!o_any && n == j && i_req[n]) begin
          o_grant[n] = 1'b1;
          o_idx      = 3'(n);
          o_any      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/gpu_mem_cmd_arbiter.sv
// Round-robin arbiter with lock and watchdog feeding the GPU memory command FIFO
// through a registered single-entry output stage.
module gpu_mem_cmd_arbiter
  import gpu_def::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int ADR_W        = 17,
  parameter int DATA_W       = 32,
  parameter int LOCK_TIMEOUT = 63
) (
  input  logic                      i_clk,
  input  logic                      i_nrst,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ-1:0]        i_lock,
  input  logic [3*NUM_REQ-1:0]      i_cmd,
  input  logic [ADR_W*NUM_REQ-1:0]  i_adr,
  input  logic [DATA_W*NUM_REQ-1:0] i_data,
  output logic [NUM_REQ-1:0]        o_accept,
  output logic [NUM_REQ-1:0]        o_owner,
  output logic                      o_cmdValid,
  output logic [2:0]                o_cmd,
  output logic [ADR_W-1:0]          o_adr,
  output logic [DATA_W-1:0]         o_data,
  output logic [2:0]                o_src,
  input  logic                      i_fifoAccept,
  output logic                      o_lockTimeout
);

  arbState_t            state_q, state_d;
  logic [2:0]           ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   owner_q, owner_d;
  logic [2:0]           owner_idx_q, owner_idx_d;
  logic [7:0]           wd_q, wd_d;
  logic                 cmd_valid_q, cmd_valid_d;
  logic [2:0]           cmd_q, cmd_d;
  logic [ADR_W-1:0]     adr_q, adr_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [2:0]           src_q, src_d;

  logic [NUM_REQ-1:0]   req_vld, elig, win_oh;
  logic [2:0]           win_idx;
  logic                 win_any, slot_free, timeout, accept_en, lock_sel;
  logic [2:0]           cmd_sel;
  logic [ADR_W-1:0]     adr_sel;
  logic [DATA_W-1:0]    data_sel;

  always_comb begin
    req_vld = '0;
    for (int n = 0; n < NUM_REQ; n++)
      req_vld[n] = i_req[n] && (i_cmd[3*n +: 3] != MEM_CMD_NONE);
  end

  assign elig = (state_q == ARB_LOCKED) ? (req_vld & owner_q) : req_vld;

  gpu_rr_picker #(.N(NUM_REQ)) u_picker (
    .i_req   (elig),
    .i_ptr   (ptr_q),
    .o_grant (win_oh),
    .o_idx   (win_idx),
    .o_any   (win_any)
  );

  always_comb begin
    lock_sel = 1'b0;
    cmd_sel  = MEM_CMD_NONE;
    adr_sel  = '0;
    data_sel = '0;
    for (int n = 0; n < NUM_REQ; n++) begin
      if (win_oh[n]) begin
        lock_sel = i_lock[n];
        cmd_sel  = i_cmd[3*n +: 3];
        adr_sel  = i_adr[ADR_W*n +: ADR_W];
        data_sel = i_data[DATA_W*n +: DATA_W];
      end
    end
  end

  // The timeout cycle is decided from the count alone, so an owner beat arriving then is refused.
  assign slot_free     = !cmd_valid_q || i_fifoAccept;
  assign timeout       = i_nrst && (state_q == ARB_LOCKED) && (wd_q == 8'(LOCK_TIMEOUT - 1));
  assign accept_en     = i_nrst && slot_free && win_any && !timeout;
  assign o_accept      = accept_en ? win_oh : '0;
  assign o_lockTimeout = timeout;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    owner_idx_d = owner_idx_q;
    wd_d        = wd_q;
    cmd_valid_d = cmd_valid_q;
    cmd_d       = cmd_q;
    adr_d       = adr_q;
    data_d      = data_q;
    src_d       = src_q;
    if (accept_en) begin
      cmd_valid_d = 1'b1;
      cmd_d       = cmd_sel;
      adr_d       = adr_sel;
      data_d      = data_sel;
      src_d       = win_idx;
    end else if (i_fifoAccept) begin
      cmd_valid_d = 1'b0;
    end
    case (state_q)
      ARB_OPEN: begin
        wd_d = '0;
        if (accept_en) begin
          if (lock_sel) begin
            state_d     = ARB_LOCKED;
            owner_d     = win_oh;
            owner_idx_d = win_idx;
          end else begin
            ptr_d = rr_next(win_idx, NUM_REQ);
          end
        end
      end
      ARB_LOCKED: begin
        if (timeout || (accept_en && !lock_sel)) begin
          state_d = ARB_OPEN;
          ptr_d   = rr_next(owner_idx_q, NUM_REQ);
          owner_d = '0;
          wd_d    = '0;
        end else if (accept_en) begin
          wd_d = '0;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      default: state_d = ARB_OPEN;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state_q     <= ARB_OPEN;
      ptr_q       <= '0;
      owner_q     <= '0;
      owner_idx_q <= '0;
      wd_q        <= '0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= MEM_CMD_NONE;
      adr_q       <= '0;
      data_q      <= '0;
      src_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      owner_idx_q <= owner_idx_d;
      wd_q        <= wd_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
      adr_q       <= adr_d;
      data_q      <= data_d;
      src_q       <= src_d;
    end
  end

  assign o_owner    = owner_q;
  assign o_cmdValid = cmd_valid_q;
  assign o_cmd      = cmd_q;
  assign o_adr      = adr_q;
  assign o_data     = data_q;
  assign o_src      = src_q;

endmodule
